fifo_sync_prog: RTL
===================

// Module: fifo_sync_prog
// PURPOSE
//  Next-generation synchronous FIFO. Width and depth are parameters, and depth need not be a power of two.
//  Adds: programmable almost-full/almost-empty thresholds, an occupancy count, a sticky high-water mark
//  and an optional first-word-fall-through (FWFT) read mode.
//  Keeps the wr_ack/overflow/underflow status semantics of the existing FIFO interface.
//  Single clock domain. Used as the general buffering primitive between producer and consumer blocks.
// PARAMETERS
//  FIFO_WIDTH  16  data word width in bits (>=1)
//  FIFO_DEPTH  8   number of entries (>=2); any integer, not restricted to a power of two
//  FWFT        0   0 = standard registered read; 1 = first-word-fall-through
//  CW          $clog2(FIFO_DEPTH+1), localparam; width of count/threshold buses
// PORTS
//  clk          in   1           clock; all logic on rising edge
//  rst          in   1           synchronous reset, active-high
//  data_in      in   FIFO_WIDTH  write data
//  wr_en        in   1           write request
//  rd_en        in   1           read request (FWFT: acknowledge/pop the head word)
//  af_thresh    in   CW          almost-full threshold, quasi-static
//  ae_thresh    in   CW          almost-empty threshold, quasi-static
//  clr_hwm      in   1           clear the high-water mark
//  data_out     out  FIFO_WIDTH  read data
//  wr_ack       out  1           previous-cycle write was accepted
//  overflow     out  1           previous-cycle write was rejected (FIFO full)
//  underflow    out  1           previous-cycle read was rejected (FIFO empty)
//  full         out  1           count == FIFO_DEPTH
//  empty        out  1           count == 0
//  almostfull   out  1           count >= af_thresh
//  almostempty  out  1           count <= ae_thresh
//  count        out  CW          current occupancy, registered
//  hwm          out  CW          maximum count since reset or clr_hwm
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - wr_ptr, rd_ptr, count, hwm go to 0; data_out, wr_ack, overflow, underflow go to 0.
//   - Memory contents are not cleared. wr_en/rd_en in that cycle are ignored.
//   - Applies identically mid-operation: all stored words are discarded.
//  Acceptance is evaluated against the registered count at the edge:
//   - write accepted iff wr_en && !full; read accepted iff rd_en && !empty.
//   - At full, rd_en+wr_en: read accepted, write rejected (overflow). At empty, both: write accepted, read rejected (underflow).
//  Write accepted: mem[wr_ptr] <= data_in; wr_ptr <= (wr_ptr==FIFO_DEPTH-1) ? 0 : wr_ptr+1.
//  Read accepted: rd_ptr advances with the same wrap rule.
//  count: +1 on write only, -1 on read only, unchanged when both or neither are accepted. Never exceeds FIFO_DEPTH; never below 0.
//  Status outputs (registered, 1-cycle pulse after the request edge, all 0 otherwise):
//   - wr_ack = write accepted
//   - overflow = wr_en && full
//   - underflow = rd_en && empty
//  full/empty/almostfull/almostempty are combinational from registered count and the threshold inputs.
//   - af_thresh=0 forces almostfull=1. ae_thresh>=FIFO_DEPTH forces almostempty=1.
//  hwm <= max(hwm, next count) each cycle. clr_hwm loads the next count instead; rst takes priority.
//  FWFT=0: data_out <= mem[rd_ptr] on an accepted read (1-cycle latency); otherwise it holds its last value.
//  FWFT=1: data_out = mem[rd_ptr] combinationally and is valid whenever empty=0.
//   - First word is visible the cycle after its write edge. rd_en pops it and the next word appears after that edge.
//   - data_out is don't-care when empty=1.
//  No read-before-write bypass: a word written at an edge is never readable at that same edge.
// TESTING
//  1 DEPTH=8: reset, write 0x0001..0x0008 -> wr_ack each cycle, count=8, full=1; 9th write -> overflow=1, count stays 8.
//  2 Read 8 words (FWFT=0) -> data_out 0x0001..0x0008 one cycle after each rd_en; 9th read -> underflow=1, data_out holds 0x0008.
//  3 DEPTH=6: write 4, read 4, then write 0x10..0x15 -> wr_ptr wraps 5->0, full=1 at count=6, readback 0x10..0x15 in order.
//  4 Simultaneous rd+wr: count=3 -> stays 3; full -> count=7, overflow=1; empty -> count=1, underflow=1.
//  5 af_thresh=6, ae_thresh=2: count=2 -> almostempty=1; count=3 -> 0; count=6 -> almostfull=1; hwm=6, clr_hwm at count=4 -> hwm=4.
//  6 FWFT=1: write 0xA5A5 -> next cycle empty=0, data_out=0xA5A5 with no rd_en; rst at count=5 -> count=0, empty=1, hwm=0.

Source files
------------

// File: rtl/fifo_sync_prog_if.sv
// Handshake/data bundle for fifo_sync_prog.
// master = producer/consumer side, slave = the FIFO itself.
interface fifo_sync_prog_if #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH+1);

   logic [FIFO_WIDTH-1:0] data_in;
   logic                  wr_en;
   logic                  rd_en;
   logic [CW-1:0]         af_thresh;
   logic [CW-1:0]         ae_thresh;
   logic                  clr_hwm;
   logic [FIFO_WIDTH-1:0] data_out;
   logic                  wr_ack;
   logic                  overflow;
   logic                  underflow;
   logic                  full;
   logic                  empty;
   logic                  almostfull;
   logic                  almostempty;
   logic [CW-1:0]         count;
   logic [CW-1:0]         hwm;

   modport master (
      output data_in, wr_en, rd_en, af_thresh, ae_thresh, clr_hwm,
      input  data_out, wr_ack, overflow, underflow, full, empty,
             almostfull, almostempty, count, hwm
   );

   modport slave (
      input  data_in, wr_en, rd_en, af_thresh, ae_thresh, clr_hwm,
      output data_out, wr_ack, overflow, underflow, full, empty,
             almostfull, almostempty, count, hwm
   );
endinterface

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO, arbitrary depth, programmable almost-full/empty,
// occupancy count, sticky high-water mark, optional FWFT read mode.
module fifo_sync_prog #(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter bit FWFT       = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   fifo_sync_prog_if.slave bus
);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]         r_count, r_hwm, w_count_nxt;
   logic                  r_wr_ack, r_overflow, r_underflow;
   logic                  w_full, w_empty, w_wr_acc, w_rd_acc;

   // Acceptance is judged against the registered count only, so a
   // simultaneous read never frees room for a write at a full FIFO.
   assign w_full   = (r_count == CW'(FIFO_DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_wr_acc = bus.wr_en && !w_full;
   assign w_rd_acc = bus.rd_en && !w_empty;

   // Next occupancy: a paired read+write leaves it unchanged.
   always_comb begin
      w_count_nxt = r_count;
      if (w_wr_acc && !w_rd_acc)
         w_count_nxt = r_count + CW'(1);
      else if (!w_wr_acc && w_rd_acc)
         w_count_nxt = r_count - CW'(1);
   end

   // Storage; never reset, and writes are dropped during reset.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_acc)
         r_mem[r_wr_ptr] <= bus.data_in;
   end

   // Pointers wrap explicitly so non-power-of-two depths work.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_acc)
            r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_wr_ptr + PW'(1);
         if (w_rd_acc)
            r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_rd_ptr + PW'(1);
      end
   end

   // Occupancy count and one-cycle status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count     <= '0;
         r_wr_ack    <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_count     <= w_count_nxt;
         r_wr_ack    <= w_wr_acc;
         r_overflow  <= bus.wr_en && w_full;
         r_underflow <= bus.rd_en && w_empty;
      end
   end

   // High-water mark tracks the post-edge count; clear reloads it.
   always_ff @(posedge clk) begin
      if (rst)
         r_hwm <= '0;
      else if (bus.clr_hwm)
         r_hwm <= w_count_nxt;
      else if (w_count_nxt > r_hwm)
         r_hwm <= w_count_nxt;
   end

   generate
      if (FWFT) begin : g_fwft
         // Head word is presented directly; meaningless while empty.
         assign bus.data_out = r_mem[r_rd_ptr];
      end else begin : g_std
         logic [FIFO_WIDTH-1:0] r_dout;
         // Registered read: updates only on an accepted read.
         always_ff @(posedge clk) begin
            if (rst)
               r_dout <= '0;
            else if (w_rd_acc)
               r_dout <= r_mem[r_rd_ptr];
         end
         assign bus.data_out = r_dout;
      end
   endgenerate

   assign bus.full        = w_full;
   assign bus.empty       = w_empty;
   assign bus.almostfull  = (r_count >= bus.af_thresh);
   assign bus.almostempty = (r_count <= bus.ae_thresh);
   assign bus.count       = r_count;
   assign bus.hwm         = r_hwm;
   assign bus.wr_ack      = r_wr_ack;
   assign bus.overflow    = r_overflow;
   assign bus.underflow   = r_underflow;
endmodule
